mult32_seq: RTL and testbench
=============================

Name: mult32_seq

Overview:
- Sequences the shared 16x16 unsigned shift-add multiplier (Multiplicador) to perform the CPU's 32x32 MULT/MULTU.
- Splits operands into halves and issues up to four partial products through the single multiplier, accumulating into a 64-bit result.
- Applies sign correction and presents the HI/LO values to the execute stage with a busy/valid handshake.
- Sits between the execute stage and the multiplier instance.

Parameters:
SKIP_ZERO, 1, when 1 a pass whose 16-bit operand half is zero is skipped (partial product taken as 0, no MulSt issued)
TIMEOUT, 64, maximum cycles spent in WAIT for MulDone before aborting with Err

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
Req  in  1  start request, sampled only in IDLE
Signed  in  1  1 = MULT (two's complement), 0 = MULTU; captured with Req
OpA  in  32  multiplicand, captured with Req
OpB  in  32  multiplier, captured with Req
Busy  out  1  high from cycle after accepted Req until the Valid cycle inclusive
Valid  out  1  one-cycle pulse: Hi/Lo hold the new result
Err  out  1  one-cycle pulse with Valid when a pass timed out; Hi/Lo forced to 0
Hi  out  32  result bits 63:32, held until the next Valid
Lo  out  32  result bits 31:0, held until the next Valid
MulSt  out  1  start pulse to the multiplier (St)
MulA  out  16  Multiplicando to the multiplier, stable from ISSUE until Done
MulB  out  16  Multiplicador to the multiplier, stable from ISSUE until Done
MulProduto  in  32  Produto from the multiplier
MulDone  in  1  Done from the multiplier
MulIdle  in  1  Idle from the multiplier

Behaviour:
- Reset (any time, including mid-operation):
  - FSM goes to IDLE.
  - Busy, Valid, Err, MulSt = 0.
  - Hi, Lo, MulA, MulB, accumulator, pass index = 0.
- Multiplier contract:
  - MulSt is a one-cycle pulse, issued only while MulIdle = 1.
  - The multiplier captures operands on that edge.
  - MulProduto is valid in the first cycle MulDone = 1.
- States and transitions:
  - IDLE: when Req = 1, capture Signed, OpA and OpB, then go to CONV. Req in any other state is ignored; there is no queue.
  - CONV (1 cycle):
    - If Signed, compute magA = |OpA| and magB = |OpB| as 32-bit unsigned (0x80000000 stays 0x80000000).
    - Compute neg = sign(OpA) XOR sign(OpB). When Signed = 0, neg = 0 and the operands pass through.
    - Set k = 0, acc = 0.
  - SEL (1 cycle): choose the halves for pass k.
    - k=0: AL*BL, shift 0
    - k=1: AL*BH, shift 16
    - k=2: AH*BL, shift 16
    - k=3: AH*BH, shift 32
    - If SKIP_ZERO and either chosen half is 0, increment k and stay in SEL; after k = 3, go to FIX.
    - Otherwise drive MulA/MulB and go to ISSUE.
  - ISSUE: wait while MulIdle = 0. When MulIdle = 1, assert MulSt for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT:
    - On MulDone = 1, go to ACC.
    - Each cycle without MulDone increments the counter. At TIMEOUT, go to DONE with the error flag set; no further MulSt is issued.
  - ACC (1 cycle):
    - acc += zero-extended MulProduto shifted by the pass shift. 64-bit add; carry out of bit 63 cannot occur.
    - k++; go to SEL, or to FIX after k = 3.
  - FIX (1 cycle): if neg, acc = two's-complement negation of acc (64-bit).
  - DONE (1 cycle):
    - Normal completion: Hi/Lo = acc; Valid = 1.
    - Timeout: Hi/Lo = 0; Valid = 1 and Err = 1.
    - Return to IDLE. A Req in the same cycle is not accepted; it is accepted next cycle.
- Latency:
  - With multiplier latency L (MulSt to MulDone) and an idle multiplier, each issued pass costs L + 3 cycles (SEL, ISSUE, L, ACC).
  - Each skipped pass costs 1 cycle.
  - Overhead: CONV, FIX, DONE = 3 cycles.
  - Valid arrives 3 + sum(pass costs) cycles after the Req cycle.
- All-zero skip: if every pass is skipped, no MulSt is issued and the result is 0 (neg is irrelevant).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, CONV, SEL, ISSUE, WAIT, ACC, FIX, DONE).
  - Pass-table constants: half selects and shift amounts.
  - MUL_HALF_W = 16.
- One sub-module: mult32_fix, a combinational magnitude/negation unit (32-bit abs with sign out; 64-bit conditional negate).
- Instantiated once for the CONV stage and once for the FIX stage.

Test Plan:
- Unsigned OpA = OpB = 0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001; 4 MulSt pulses; Err = 0.
- Signed -2 x 3 (0xFFFFFFFE, 0x00000003) -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFA; Signed 0x80000000 x 0x80000000 -> Hi = 0x40000000, Lo = 0.
- SKIP_ZERO = 1, unsigned 0x00001234 x 0x00005678 -> exactly 1 MulSt; Hi = 0, Lo = 0x06260060; Valid at 3 + (L+3) + 3 cycles after Req.
- Multiplier model with MulDone stuck at 0 -> Valid and Err pulse together after TIMEOUT WAIT cycles; Hi = Lo = 0; exactly one MulSt issued.
- Req pulsed while Busy -> ignored (no second Valid); Reset asserted in WAIT -> Busy and MulSt drop immediately, Hi = Lo = 0; next Req completes correctly.
- Random signed/unsigned operand sweep vs 64-bit reference product, with variable L and MulIdle delay -> all results match, Busy/Valid protocol held.

Source files
------------

// File: rtl/mult32_seq_pkg.sv
// Shared types and constants for the 32x32 multiply sequencer.
package mult32_seq_pkg;

    localparam int unsigned MUL_HALF_W = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ACC_W      = 64;
    localparam int unsigned SHIFT_W    = 6;
    localparam int unsigned PASS_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SEL,
        ST_ISSUE,
        ST_WAIT,
        ST_ACC,
        ST_FIX,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic               a_hi;
        logic               b_hi;
        logic [SHIFT_W-1:0] shift;
    } pass_t;

    // Partial-product order: AL*BL, AL*BH, AH*BL, AH*BH.
    function automatic pass_t pass_entry(input logic [PASS_W-1:0] k);
        pass_t p;
        case (k)
            2'd0:    p = '{a_hi: 1'b0, b_hi: 1'b0, shift: SHIFT_W'(0)};
            2'd1:    p = '{a_hi: 1'b0, b_hi: 1'b1, shift: SHIFT_W'(16)};
            2'd2:    p = '{a_hi: 1'b1, b_hi: 1'b0, shift: SHIFT_W'(16)};
            default: p = '{a_hi: 1'b1, b_hi: 1'b1, shift: SHIFT_W'(32)};
        endcase
        return p;
    endfunction

    function automatic logic [MUL_HALF_W-1:0] half_sel(input logic [DATA_W-1:0] v,
                                                        input logic hi);
        return hi ? v[DATA_W-1:MUL_HALF_W] : v[MUL_HALF_W-1:0];
    endfunction

endpackage

// File: rtl/mult32_fix.sv
// Combinational magnitude/sign unit: 32-bit abs of two operands and 64-bit conditional negate.
module mult32_fix
    import mult32_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sign_en,
    input  logic [ACC_W-1:0]  acc,
    input  logic              acc_neg,
    output logic [DATA_W-1:0] mag_a_c,
    output logic [DATA_W-1:0] mag_b_c,
    output logic              neg_c,
    output logic [ACC_W-1:0]  acc_out_c
);

    logic sign_a;
    logic sign_b;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    always_comb begin
        sign_a    = sign_en & a[DATA_W-1];
        sign_b    = sign_en & b[DATA_W-1];
        mag_a_c   = sign_a ? (~a + DATA_W'(1)) : a;
        mag_b_c   = sign_b ? (~b + DATA_W'(1)) : b;
        neg_c     = sign_a ^ sign_b;
        acc_out_c = acc_neg ? (~acc + ACC_W'(1)) : acc;
    end

endmodule

// File: rtl/mult32_seq.sv
// Sequences a shared 16x16 multiplier through up to four passes to form a 32x32 MULT/MULTU result.
module mult32_seq
    import mult32_seq_pkg::*;
#(
    parameter bit          SKIP_ZERO = 1'b1,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  Signed,
    input  logic [DATA_W-1:0]     OpA,
    input  logic [DATA_W-1:0]     OpB,
    output logic                  Busy,
    output logic                  Valid,
    output logic                  Err,
    output logic [DATA_W-1:0]     Hi,
    output logic [DATA_W-1:0]     Lo,
    output logic                  MulSt,
    output logic [MUL_HALF_W-1:0] MulA,
    output logic [MUL_HALF_W-1:0] MulB,
    input  logic [DATA_W-1:0]     MulProduto,
    input  logic                  MulDone,
    input  logic                  MulIdle
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state;
    logic                sgn;
    logic                neg;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [PASS_W-1:0]   k;
    logic [ACC_W-1:0]    acc;
    logic [DATA_W-1:0]   prod;
    logic [TMO_W-1:0]    tmo_cnt;

    pass_t               pass_c;
    logic [MUL_HALF_W-1:0] half_a_c;
    logic [MUL_HALF_W-1:0] half_b_c;
    logic                skip_c;
    logic [ACC_W-1:0]    prod_shifted_c;

    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic                conv_neg;
    logic [ACC_W-1:0]    acc_fixed;
    logic [ACC_W-1:0]    conv_acc_unused;
    logic [DATA_W-1:0]   fix_mag_a_unused;
    logic [DATA_W-1:0]   fix_mag_b_unused;
    logic                fix_neg_unused;

    // Current pass operands and shifted partial product.
    always_comb begin
        pass_c         = pass_entry(k);
        half_a_c       = half_sel(op_a, pass_c.a_hi);
        half_b_c       = half_sel(op_b, pass_c.b_hi);
        skip_c         = SKIP_ZERO && ((half_a_c == '0) || (half_b_c == '0));
        prod_shifted_c = ACC_W'(prod) << pass_c.shift;
    end

    mult32_fix u_conv (
        .a         (op_a),
        .b         (op_b),
        .sign_en   (sgn),
        .acc       ('0),
        .acc_neg   (1'b0),
        .mag_a_c   (mag_a),
        .mag_b_c   (mag_b),
        .neg_c     (conv_neg),
        .acc_out_c (conv_acc_unused)
    );

    mult32_fix u_fix (
        .a         ('0),
        .b         ('0),
        .sign_en   (1'b0),
        .acc       (acc),
        .acc_neg   (neg),
        .mag_a_c   (fix_mag_a_unused),
        .mag_b_c   (fix_mag_b_unused),
        .neg_c     (fix_neg_unused),
        .acc_out_c (acc_fixed)
    );

    // Sequencer; MulSt is registered so it is high during the ISSUE cycle it belongs to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            sgn     <= 1'b0;
            neg     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            k       <= '0;
            acc     <= '0;
            prod    <= '0;
            tmo_cnt <= '0;
            Busy    <= 1'b0;
            Valid   <= 1'b0;
            Err     <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            MulSt   <= 1'b0;
            MulA    <= '0;
            MulB    <= '0;
        end else begin
            Valid <= 1'b0;
            Err   <= 1'b0;
            MulSt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        sgn   <= Signed;
                        op_a  <= OpA;
                        op_b  <= OpB;
                        Busy  <= 1'b1;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    op_a  <= mag_a;
                    op_b  <= mag_b;
                    neg   <= conv_neg;
                    k     <= '0;
                    acc   <= '0;
                    state <= ST_SEL;
                end
                ST_SEL: begin
                    if (skip_c) begin
                        k     <= k + PASS_W'(1);
                        state <= (k == PASS_W'(3)) ? ST_FIX : ST_SEL;
                    end else begin
                        MulA  <= half_a_c;
                        MulB  <= half_b_c;
                        MulSt <= MulIdle;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    if (MulSt) begin
                        state <= ST_WAIT;
                    end else if (MulIdle) begin
                        MulSt <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (MulDone) begin
                        prod  <= MulProduto;
                        state <= ST_ACC;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        Hi    <= '0;
                        Lo    <= '0;
                        Valid <= 1'b1;
                        Err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_ACC: begin
                    acc   <= acc + prod_shifted_c;
                    k     <= k + PASS_W'(1);
                    state <= (k == PASS_W'(3)) ? ST_FIX : ST_SEL;
                end
                ST_FIX: begin
                    acc   <= acc_fixed;
                    Hi    <= acc_fixed[ACC_W-1:DATA_W];
                    Lo    <= acc_fixed[DATA_W-1:0];
                    Valid <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq with a behavioural 16x16 multiplier model.
module tb_mult32_seq;

    localparam int unsigned TMO = 64;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        Busy, Valid, Err, MulSt, MulDone, MulIdle;
    logic [31:0] Hi, Lo, MulProduto;
    logic [15:0] MulA, MulB;

    int n_vec = 0;
    int n_bad = 0;
    int st_count = 0;
    int proto_bad = 0;

    // Multiplier model controls.
    int unsigned lat = 3;
    int unsigned idle_dly = 0;
    bit          stuck = 1'b0;

    logic [15:0] m_a, m_b;
    logic        m_idle, m_active;
    int unsigned m_cnt, idle_cnt;
    logic        prev_st;

    mult32_seq #(.SKIP_ZERO(1'b1), .TIMEOUT(TMO)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .Signed     (Signed),
        .OpA        (OpA),
        .OpB        (OpB),
        .Busy       (Busy),
        .Valid      (Valid),
        .Err        (Err),
        .Hi         (Hi),
        .Lo         (Lo),
        .MulSt      (MulSt),
        .MulA       (MulA),
        .MulB       (MulB),
        .MulProduto (MulProduto),
        .MulDone    (MulDone),
        .MulIdle    (MulIdle)
    );

    always #5 Clk = ~Clk;

    // Done is high in the cycle L cycles after the St cycle.
    assign MulDone    = m_active && !stuck && (m_cnt == 1);
    assign MulProduto = 32'(m_a) * 32'(m_b);
    assign MulIdle    = m_idle;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_idle   <= 1'b1;
            m_active <= 1'b0;
            m_cnt    <= 0;
            idle_cnt <= 0;
            m_a      <= '0;
            m_b      <= '0;
        end else if (MulSt && m_idle) begin
            m_a      <= MulA;
            m_b      <= MulB;
            m_idle   <= 1'b0;
            m_active <= 1'b1;
            m_cnt    <= lat;
        end else if (m_active) begin
            if (!stuck) begin
                if (m_cnt == 1) begin
                    m_active <= 1'b0;
                    if (idle_dly == 0) m_idle <= 1'b1;
                    else idle_cnt <= idle_dly;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end else if (idle_cnt != 0) begin
            idle_cnt <= idle_cnt - 1;
            if (idle_cnt == 1) m_idle <= 1'b1;
        end
    end

    always @(posedge Clk) begin
        if (!Reset && MulSt) st_count <= st_count + 1;
    end

    // Handshake rules observed every cycle.
    always @(negedge Clk) begin
        if (Reset) begin
            prev_st <= 1'b0;
        end else begin
            if (Valid && !Busy) proto_bad <= proto_bad + 1;
            if (Err && !Valid) proto_bad <= proto_bad + 1;
            if (MulSt && (!MulIdle || prev_st)) proto_bad <= proto_bad + 1;
            prev_st <= MulSt;
        end
    end

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            return 64'(x * y);
        end
        return 64'(a) * 64'(b);
    endfunction

    function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
        return (s && v[31]) ? 32'(-v) : v;
    endfunction

    function automatic int n_issued(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        int n;
        ma = mag(s, a);
        mb = mag(s, b);
        n = 0;
        if (ma[15:0]  != 0 && mb[15:0]  != 0) n++;
        if (ma[15:0]  != 0 && mb[31:16] != 0) n++;
        if (ma[31:16] != 0 && mb[15:0]  != 0) n++;
        if (ma[31:16] != 0 && mb[31:16] != 0) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction: drive Req, wait for Valid, compare with the reference.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned lat_i, input int unsigned idly, input bit chk_lat,
                          input bit busy_req, input bit to_mode);
        logic [63:0] exp_p;
        int cyc, sts0, n, exp_c, exp_sts;
        lat = lat_i;
        idle_dly = idly;
        n = n_issued(s, a, b);
        if (to_mode) begin
            exp_p = '0;
            exp_sts = 1;
            exp_c = 4 + int'(TMO);
        end else begin
            exp_p = ref_mul(s, a, b);
            exp_sts = n;
            exp_c = 3 + n * (int'(lat_i) + 3) + (4 - n);
        end
        @(negedge Clk);
        Req = 1'b1; Signed = s; OpA = a; OpB = b;
        sts0 = st_count;
        @(negedge Clk);
        Req = 1'b0; Signed = ~s; OpA = $urandom; OpB = $urandom;
        cyc = 1;
        while (!Valid && cyc < 400) begin
            Req = (busy_req && cyc == 3);
            @(negedge Clk);
            cyc++;
        end
        Req = 1'b0;
        check({tag, ".valid"}, 64'(Valid), 64'd1);
        check({tag, ".hi"}, 64'(Hi), 64'(exp_p[63:32]));
        check({tag, ".lo"}, 64'(Lo), 64'(exp_p[31:0]));
        check({tag, ".err"}, 64'(Err), 64'(to_mode));
        check({tag, ".busy"}, 64'(Busy), 64'd1);
        check({tag, ".mulst_cnt"}, 64'(st_count - sts0), 64'(exp_sts));
        if (chk_lat) check({tag, ".latency"}, 64'(cyc), 64'(exp_c));
        @(negedge Clk);
        check({tag, ".valid_drop"}, 64'(Valid), 64'd0);
        check({tag, ".busy_drop"}, 64'(Busy), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v[15:0] = '0;
        if ($urandom_range(0, 3) == 0) v[31:16] = '0;
        if ($urandom_range(0, 15) == 0) v = 32'h8000_0000;
        return v;
    endfunction

    initial begin
        int extra;
        logic s;
        logic [31:0] a, b;
        int unsigned l, d;

        repeat (2) @(negedge Clk);
        check("rst.busy", 64'(Busy), 64'd0);
        check("rst.valid", 64'(Valid), 64'd0);
        check("rst.err", 64'(Err), 64'd0);
        check("rst.mulst", 64'(MulSt), 64'd0);
        check("rst.hilo", {Hi, Lo}, 64'd0);
        check("rst.mulab", 64'({MulA, MulB}), 64'd0);
        Reset = 1'b0;

        run_op("u_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0, 1'b1, 1'b0, 1'b0);
        check("u_ff.hi_const", 64'(Hi), 64'h0000_0000_FFFF_FFFE);
        check("u_ff.lo_const", 64'(Lo), 64'h0000_0000_0000_0001);
        run_op("s_m2x3", 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 2, 0, 1'b1, 1'b0, 1'b0);
        check("s_m2x3.lo_const", 64'(Lo), 64'h0000_0000_FFFF_FFFA);
        run_op("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 3, 0, 1'b1, 1'b0, 1'b0);
        check("s_min2.hi_const", 64'(Hi), 64'h0000_0000_4000_0000);
        run_op("u_skip", 1'b0, 32'h0000_1234, 32'h0000_5678, 5, 0, 1'b1, 1'b0, 1'b0);
        check("u_skip.lo_const", 64'(Lo), 64'h0000_0000_0626_0060);
        run_op("zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 3, 0, 1'b1, 1'b0, 1'b0);
        run_op("busy_req", 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 3, 1, 1'b0, 1'b1, 1'b0);
        extra = 0;
        repeat (30) begin
            @(negedge Clk);
            if (Valid) extra++;
        end
        check("busy_req.no_second_valid", 64'(extra), 64'd0);

        // Stuck multiplier: timeout, then reset to recover the model.
        stuck = 1'b1;
        run_op("timeout", 1'b0, 32'h0001_0001, 32'h0001_0001, 3, 0, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        stuck = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;

        run_op("pre_rst", 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 0, 1'b1, 1'b0, 1'b0);
        lat = 20;
        @(negedge Clk);
        Req = 1'b1; Signed = 1'b0; OpA = 32'h0003_0005; OpB = 32'h0007_0009;
        @(negedge Clk);
        Req = 1'b0;
        repeat (5) @(negedge Clk);
        check("mid_rst.busy_before", 64'(Busy), 64'd1);
        Reset = 1'b1;
        #1;
        check("mid_rst.busy", 64'(Busy), 64'd0);
        check("mid_rst.mulst", 64'(MulSt), 64'd0);
        check("mid_rst.hilo", {Hi, Lo}, 64'd0);
        check("mid_rst.valid", 64'(Valid), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_op("post_rst", 1'b1, 32'h8765_4321, 32'h0000_FFFF, 3, 0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = rand_op();
            b = rand_op();
            l = $urandom_range(1, 6);
            d = $urandom_range(0, 3);
            run_op($sformatf("rand%0d", i), s, a, b, l, d, (d == 0), 1'b0, 1'b0);
        end

        check("protocol", 64'(proto_bad), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
